// File: rtl/carry_select_adder_pkg.sv
// Shared helpers for the carry-select adder: segment-count arithmetic.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package carry_select_adder_pkg;

    function automatic int csa_ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/csa_ripple_block.sv
// W-bit ripple-carry adder segment, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
module csa_ripple_block #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic c;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/carry_select_adder.sv
// WIDE-bit carry-select adder (a + b + carry_go) with registered sum/carry-out.
// Latency: 1 cycle, new result every cycle.
// Backpressure: none, outputs hold between clock edges.
module carry_select_adder
    import carry_select_adder_pkg::*;
#(
    parameter int WIDE  = 4,
    parameter int BLOCK = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WIDE-1:0] a,
    input  logic [WIDE-1:0] b,
    input  logic            carry_go,
    output logic [WIDE-1:0] sum,
    output logic            carry_get
);

    localparam int NSEG   = csa_ceil_div(WIDE, BLOCK);
    localparam int LAST_W = WIDE - (NSEG - 1) * BLOCK;

    logic [WIDE-1:0] sum_c;
    logic            carry_c;

    for (genvar k = 0; k < NSEG; k++) begin : gen_seg
        localparam int LO = k * BLOCK;
        localparam int W  = (k == NSEG - 1) ? LAST_W : BLOCK;

        logic [W-1:0] seg_sum;
        logic         seg_cout;

        if (k == 0) begin : gen_first
            csa_ripple_block #(.W(W)) u_rca (
                .a    (a[LO +: W]),
                .b    (b[LO +: W]),
                .cin  (carry_go),
                .sum  (seg_sum),
                .cout (seg_cout)
            );
        end else begin : gen_sel
            logic [W-1:0] sum0, sum1;
            logic         cout0, cout1;
            logic         seg_cin;

            // Both candidates settle in parallel; only the mux sits on the chain.
            csa_ripple_block #(.W(W)) u_rca0 (
                .a    (a[LO +: W]),
                .b    (b[LO +: W]),
                .cin  (1'b0),
                .sum  (sum0),
                .cout (cout0)
            );
            csa_ripple_block #(.W(W)) u_rca1 (
                .a    (a[LO +: W]),
                .b    (b[LO +: W]),
                .cin  (1'b1),
                .sum  (sum1),
                .cout (cout1)
            );

            assign seg_cin  = gen_seg[k-1].seg_cout;
            assign seg_sum  = seg_cin ? sum1  : sum0;
            assign seg_cout = seg_cin ? cout1 : cout0;
        end

        assign sum_c[LO +: W] = seg_sum;
    end

    assign carry_c = gen_seg[NSEG-1].seg_cout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum       <= '0;
            carry_get <= 1'b0;
        end else begin
            sum       <= sum_c;
            carry_get <= carry_c;
        end
    end

endmodule

// File: tb/tb_carry_select_adder.sv
module tb_carry_select_adder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] a4 = 4'hF, b4 = 4'hF;
    logic       c4 = 1'b1;
    logic [6:0] a7 = 7'h7F, b7 = 7'h7F;
    logic       c7 = 1'b1;

    logic [3:0] sum4, sum4w;
    logic       cy4, cy4w;
    logic [6:0] sum7;
    logic       cy7;

    logic [4:0] q4[$];
    logic [7:0] q7[$];
    logic [4:0] e4;
    logic [7:0] e7;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    carry_select_adder #(.WIDE(4), .BLOCK(2)) u_w4b2 (
        .clk(clk), .reset(reset), .a(a4), .b(b4), .carry_go(c4),
        .sum(sum4), .carry_get(cy4)
    );
    carry_select_adder #(.WIDE(4), .BLOCK(8)) u_w4b8 (
        .clk(clk), .reset(reset), .a(a4), .b(b4), .carry_go(c4),
        .sum(sum4w), .carry_get(cy4w)
    );
    carry_select_adder #(.WIDE(7), .BLOCK(3)) u_w7b3 (
        .clk(clk), .reset(reset), .a(a7), .b(b7), .carry_go(c7),
        .sum(sum7), .carry_get(cy7)
    );

    // Drives both operand sets and records their full-precision sums.
    task automatic drive(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                         input logic [6:0] ya, input logic [6:0] yb, input logic yc);
        a4 = xa; b4 = xb; c4 = xc;
        a7 = ya; b7 = yb; c7 = yc;
        q4.push_back({1'b0, xa} + {1'b0, xb} + {4'b0, xc});
        q7.push_back({1'b0, ya} + {1'b0, yb} + {7'b0, yc});
    endtask

    task automatic test_reset;
        #1;
        n_vec++; if ({cy4, sum4} !== 5'h00) begin n_err++; $display("FAIL reset_imm_w4b2: got %h want 00", {cy4, sum4}); end
        n_vec++; if ({cy4w, sum4w} !== 5'h00) begin n_err++; $display("FAIL reset_imm_w4b8: got %h want 00", {cy4w, sum4w}); end
        n_vec++; if ({cy7, sum7} !== 8'h00) begin n_err++; $display("FAIL reset_imm_w7b3: got %h want 00", {cy7, sum7}); end
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({cy4, sum4} !== 5'h00) begin n_err++; $display("FAIL reset_hold_w4b2: got %h want 00", {cy4, sum4}); end
        n_vec++; if ({cy7, sum7} !== 8'h00) begin n_err++; $display("FAIL reset_hold_w7b3: got %h want 00", {cy7, sum7}); end
        @(negedge clk);
        reset = 1'b0;
        drive(4'hF, 4'hF, 1'b1, 7'h7F, 7'h7F, 1'b1);
        @(posedge clk); #1;
        e4 = q4.pop_front(); e7 = q7.pop_front();
        n_vec++; if ({cy4, sum4} !== 5'h1F) begin n_err++; $display("FAIL reset_release_w4b2: got %h want 1f", {cy4, sum4}); end
        n_vec++; if ({cy4w, sum4w} !== e4) begin n_err++; $display("FAIL reset_release_w4b8: got %h want %h", {cy4w, sum4w}, e4); end
        n_vec++; if ({cy7, sum7} !== 8'hFF) begin n_err++; $display("FAIL reset_release_w7b3: got %h want ff", {cy7, sum7}); end
    endtask

    // Applies a table of 4-bit vectors back to back; 7-bit side gets random operands.
    task automatic test_table(input string name, input logic [8:0] vec[], input logic [4:0] want[]);
        for (int i = 0; i < vec.size(); i++) begin
            @(negedge clk);
            drive(vec[i][8:5], vec[i][4:1], vec[i][0],
                  7'($urandom), 7'($urandom), 1'($urandom));
            @(posedge clk); #1;
            if (q4.size() == 0 || q7.size() == 0) begin
                n_vec++; n_err++; $display("FAIL %s: scoreboard empty at %0d", name, i);
            end else begin
                e4 = q4.pop_front(); e7 = q7.pop_front();
                n_vec++; if ({cy4, sum4} !== want[i]) begin n_err++; $display("FAIL %s_w4b2[%0d]: got %h want %h", name, i, {cy4, sum4}, want[i]); end
                n_vec++; if ({cy4w, sum4w} !== e4) begin n_err++; $display("FAIL %s_w4b8[%0d]: got %h want %h", name, i, {cy4w, sum4w}, e4); end
                n_vec++; if ({cy7, sum7} !== e7) begin n_err++; $display("FAIL %s_w7b3[%0d]: got %h want %h", name, i, {cy7, sum7}, e7); end
            end
        end
    endtask

    task automatic test_exhaustive;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (i == 300) begin
                reset = 1'b1;
                #1;
                n_vec++; if ({cy4, sum4, cy7, sum7} !== 13'h0) begin n_err++; $display("FAIL midreset_imm: got %h/%h want 0/0", {cy4, sum4}, {cy7, sum7}); end
                q4.delete(); q7.delete();
                @(posedge clk); #1;
                n_vec++; if ({cy4, sum4, cy7, sum7} !== 13'h0) begin n_err++; $display("FAIL midreset_hold: got %h/%h want 0/0", {cy4, sum4}, {cy7, sum7}); end
                @(negedge clk);
                reset = 1'b0;
            end
            drive(4'(i >> 5), 4'(i >> 1), i[0],
                  7'($urandom), 7'($urandom), 1'($urandom));
            @(posedge clk); #1;
            if (q4.size() != 1 || q7.size() != 1) begin
                n_vec++; n_err++; $display("FAIL exhaustive: scoreboard depth %0d at %0d", q4.size(), i);
                q4.delete(); q7.delete();
            end else begin
                e4 = q4.pop_front(); e7 = q7.pop_front();
                n_vec++; if ({cy4, sum4} !== e4) begin n_err++; $display("FAIL exh_w4b2[%0d]: got %h want %h", i, {cy4, sum4}, e4); end
                n_vec++; if ({cy4w, sum4w} !== e4) begin n_err++; $display("FAIL exh_w4b8[%0d]: got %h want %h", i, {cy4w, sum4w}, e4); end
                n_vec++; if ({cy7, sum7} !== e7) begin n_err++; $display("FAIL exh_w7b3[%0d]: got %h want %h (a=%h b=%h c=%b)", i, {cy7, sum7}, e7, a7, b7, c7); end
            end
        end
    endtask

    initial begin
        logic [8:0] v[];
        logic [4:0] w[];

        test_reset();

        // Packed as {a, b, carry_go}; expectations are {carry_get, sum}.
        v = '{{4'd1, 4'd1, 1'b0}, {4'd3, 4'd1, 1'b0}, {4'd9, 4'd3, 1'b0}, {4'd5, 4'd2, 1'b0}};
        w = '{5'h02, 5'h04, 5'h0C, 5'h07};
        test_table("basic", v, w);

        v = '{{4'b0011, 4'b0001, 1'b0}, {4'b0111, 4'b0001, 1'b0}};
        w = '{5'b0_0100, 5'b0_1000};
        test_table("cross_seg", v, w);

        v = '{{4'hF, 4'h1, 1'b0}, {4'h8, 4'h8, 1'b0}, {4'hF, 4'hF, 1'b1}, {4'h0, 4'h0, 1'b0}};
        w = '{5'h10, 5'h10, 5'h1F, 5'h00};
        test_table("overflow", v, w);

        v = '{{4'h0, 4'h0, 1'b1}, {4'hF, 4'h0, 1'b1}};
        w = '{5'h01, 5'h10};
        test_table("carry_in", v, w);

        test_exhaustive();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
